uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 4: number of tick pulses per bit period; the value SHALL be even and at least 4.
REQ-002 Parameter DATA_BITS, default 8: number of data bits per frame; the allowed range SHALL be 5 to 9.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL run on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, SHALL be asynchronous and active-high.
REQ-005 Port tick, input, 1 bit: one-clk strobe at OVERSAMPLE x baud from the baud generator; sampling logic SHALL advance only on cycles with tick=1.
REQ-006 Port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-007 Port rx_data, output, DATA_BITS: last accepted byte.
REQ-008 Port rx_valid, output, 1 bit: rx_data holds an unacknowledged byte.
REQ-009 Port rx_ack, input, 1 bit: consumer acknowledge, sampled each clk.
REQ-010 Port overrun, output, 1 bit: sticky; a good frame was dropped because rx_valid was high.
REQ-011 Port frame_err, output, 1 bit: one-clk pulse when the stop bit samples low.
REQ-012 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer (rxd_s), both flops reset to 1; all decisions SHALL use rxd_s only.
REQ-014 The state machine SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 The tick counter SHALL be clog2(OVERSAMPLE) bits wide and the bit counter clog2(DATA_BITS+1) bits wide; each SHALL reset to 0 on every state entry.
REQ-016 IDLE: on a tick with rxd_s=0, the block SHALL go to START.
REQ-017 START: the block SHALL count ticks; on the OVERSAMPLE/2-th tick it SHALL go to DATA if rxd_s=0, otherwise return to IDLE (false start, no output change).
REQ-018 DATA: the block SHALL sample rxd_s every OVERSAMPLE ticks, LSB first, shifting right into a DATA_BITS shift register; after DATA_BITS samples it SHALL go to STOP.
REQ-019 STOP: on the OVERSAMPLE-th tick, with rxd_s=1 (good frame), the block SHALL go to IDLE in the same cycle and behave as follows.
- If rx_valid=0, or rx_ack=1 in that same cycle: load rx_data from the shift register and set rx_valid=1.
- Otherwise: leave rx_data unchanged and set overrun=1.
REQ-020 STOP with rxd_s=0 SHALL pulse frame_err for exactly one clk, leave rx_data, rx_valid and overrun unchanged, and go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL go to IDLE on the first tick with rxd_s=1 (break handling); while rxd_s stays low it SHALL remain in WAIT_IDLE with busy=1.
REQ-022 rx_ack=1 with rx_valid=1 SHALL clear rx_valid and overrun on the next clk edge, unless a load per REQ-019 occurs in the same cycle, in which case rx_valid SHALL stay 1 and overrun SHALL clear.
REQ-023 rx_ack=1 with rx_valid=0 SHALL have no effect.
REQ-024 Latency: rx_valid SHALL rise on the clk edge after the stop-bit mid-sample tick, at most 1 clk after that tick.
REQ-025 Cycles with tick=0 SHALL hold all counters and the state unchanged.
REQ-026 A tick sustained high every clk SHALL be legal, giving OVERSAMPLE clk per bit.

Reset
REQ-027 On rst=1 the block SHALL immediately force:
- state=IDLE, counters=0, shift register=0, sync flops=1;
- rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release the block SHALL wait for a new falling edge, and a partially received frame SHALL never be delivered.

Verification
REQ-029 Tick every 26 clk; frame start 0, data 0xA5 LSB first, stop 1 -> rx_valid=1, rx_data=0xA5 within 1 clk of the stop mid-sample tick; frame_err=0, overrun=0; busy=0 afterwards.
REQ-030 rxd low for 1 tick period only, then high -> START aborts at the 2nd tick; rx_valid stays 0; busy returns to 0 within OVERSAMPLE/2+1 ticks.
REQ-031 Data 0x00 followed by rxd held low for 20 bit times -> one frame_err pulse, rx_valid=0, busy=1 until rxd rises, then the next frame 0x3C is received correctly.
REQ-032 Frames 0x12 then 0x34 with no ack -> rx_data=0x12, rx_valid=1, overrun=1; then rx_ack for 1 clk -> rx_valid=0, overrun=0.
REQ-033 rx_ack asserted in the same clk as frame 0x56 loads, with 0x12 pending -> rx_valid stays 1, rx_data=0x56, overrun=0.
REQ-034 rst pulsed during data bit 4 of 0xFF -> all outputs reset immediately with no rx_valid; the following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//
// Watches an asynchronous serial line (idle high) and assembles frames of
// one start bit, DATA_BITS data bits (LSB first) and one stop bit. All
// sampling advances only on cycles where the baud-generator strobe 'tick'
// is high. 'tick' runs at OVERSAMPLE times the bit rate.
//
// Parameters
//   OVERSAMPLE  ticks per bit period (even, >= 4)
//   DATA_BITS   data bits per frame (5..9)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   tick       one-clk strobe at OVERSAMPLE x baud
//   rxd        raw serial input, idle high
//   rx_ack     consumer acknowledge for the pending word
//   rx_data    last accepted word
//   rx_valid   rx_data holds an unacknowledged word
//   overrun    sticky: a good frame was dropped while rx_valid was high
//   frame_err  one-clk pulse when a stop bit samples low
//   busy       receiver is anywhere but IDLE
module uart_rx #(
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Tick-count values at which START, DATA and STOP act.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_meta, rxd_s;
  logic                 sample_en, stop_good, stop_bad;

  // Two-flop synchronizer on the asynchronous line.
  // NOTE: both flops reset to 1 (the line's idle level) so that leaving
  // reset can never look like a falling start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
    end
  end

  // Next state, counters and one-cycle control strobes. Nothing moves on
  // cycles without a tick.
  always_comb begin
    // NOTE: every output of this block gets a default first; a missing
    // default on any path would infer a latch.
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    sample_en    = 1'b0;
    stop_good    = 1'b0;
    stop_bad     = 1'b0;

    if (tick) begin
      tick_cnt_nxt = tick_cnt + TW'(1);
      case (state)
        IDLE: begin
          tick_cnt_nxt = '0;
          if (!rxd_s) state_nxt = START;
        end
        START: begin
          // Mid-point of the start bit: still low means a real frame.
          if (tick_cnt == HALF_LAST) state_nxt = rxd_s ? IDLE : DATA;
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            sample_en    = 1'b1;
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) state_nxt = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            if (rxd_s) begin
              stop_good = 1'b1;
              state_nxt = IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // Line held low (break): wait for it to return high.
          tick_cnt_nxt = '0;
          if (rxd_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase

      // Both counters restart on entry to any state.
      if (state_nxt != state) begin
        tick_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
      end
    end
  end

  // Data path and consumer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;

      // LSB arrives first, so shift right and fill from the top.
      if (sample_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};

      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      // A load in the same cycle as an ack wins over the clear above.
      if (stop_good) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
//
// A behavioural receiver model predicts every output on every clock: it
// timestamps the detected start edge in ticks and decides what each later
// tick means purely from its offset (mid start bit, mid data bit n, stop).
// Directed scenarios (false start, break, overrun, ack-on-load, reset
// mid-frame) are followed by random frames, tick rates and acks; literal
// expectations at key points pin the model itself.
module tb_uart_rx;

  localparam int OS       = 4;
  localparam int DB       = 8;
  localparam int STOP_OFF = OS / 2 + OS * (DB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          rxd;
  logic          rx_ack;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          overrun;
  logic          frame_err;
  logic          busy;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   checks      = 0;
  int   errors      = 0;
  int   tick_div    = 26;
  int   ferr_pulses = 0;
  logic ack_rand    = 1'b0;
  logic ack_force   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic          m_valid, m_ovr, m_ferr, m_busy;
  logic [DB-1:0] m_data, m_bits;
  logic          s1, s2;
  logic          m_in_frame, m_break;
  int            m_tick_idx = 0;
  int            m_start_idx = 0;
  int            m_off = 0;

  initial begin
    logic rs, stop_hit, stop_ok;
    int   idx;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        s1 = 1'b1; s2 = 1'b1;
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
        m_data = '0; m_bits = '0;
        m_in_frame = 1'b0; m_break = 1'b0; m_off = 0;
      end else begin
        rs = s2; s2 = s1; s1 = rxd;  // line as seen through two flops
        m_ferr = 1'b0; stop_hit = 1'b0; stop_ok = 1'b0;
        if (tick) begin
          m_tick_idx++;
          if (m_break) begin
            if (rs) m_break = 1'b0;
          end else if (!m_in_frame) begin
            if (!rs) begin
              m_in_frame = 1'b1; m_start_idx = m_tick_idx; m_off = 0;
            end
          end else begin
            m_off = m_tick_idx - m_start_idx;
            if (m_off == OS / 2) begin
              if (rs) m_in_frame = 1'b0;
            end else if (m_off > OS / 2 && (m_off - OS / 2) % OS == 0) begin
              idx = (m_off - OS / 2) / OS;  // 1..DB data bits, DB+1 stop
              if (idx <= DB) begin
                m_bits = (m_bits & ~(DB'(1) << (idx - 1))) | (DB'(rs) << (idx - 1));
              end else begin
                m_in_frame = 1'b0; stop_hit = 1'b1; stop_ok = rs;
                if (!rs) begin m_break = 1'b1; m_ferr = 1'b1; end
              end
            end
          end
        end
        if (stop_hit && stop_ok) begin
          if (!m_valid || rx_ack) begin
            m_data = m_bits; m_valid = 1'b1; m_ovr = 1'b0;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (rx_ack && m_valid) begin
          m_valid = 1'b0; m_ovr = 1'b0;
        end
        m_busy = m_in_frame || m_break;
      end
    end
  end

  // ---------------------------------------------------- per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_rx_valid",  32'(rx_valid),  32'(m_valid));
      check("cyc_rx_data",   32'(rx_data),   32'(m_data));
      check("cyc_overrun",   32'(overrun),   32'(m_ovr));
      check("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
      check("cyc_busy",      32'(busy),      32'(m_busy));
      if (frame_err === 1'b1) ferr_pulses++;
    end
  end

  // ------------------------------------------------------ input drivers
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (tick_div <= 1) begin
        tick = 1'b1; cnt = 0;
      end else begin
        tick = (cnt == 0);
        cnt  = (cnt >= tick_div - 1) ? 0 : cnt + 1;
      end
    end
  end

  initial begin
    rx_ack = 1'b0;
    forever begin
      @(posedge clk); #3;
      rx_ack = ack_force || (ack_rand && ($urandom_range(0, 7) == 0));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick) c++;
      #2;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    wait_ticks(n);
  endtask

  // Sends start, data LSB first, then leaves rxd at stop_bit for one bit.
  // rst_bit >= 0 pulses reset halfway through that data bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input int rst_bit);
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      if (i == rst_bit) begin
        wait_ticks(OS / 2);
        rst = 1'b1;
        #1;
        check("rst_mid_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_mid_rx_data",   32'(rx_data),   32'h0);
        check("rst_mid_overrun",   32'(overrun),   32'h0);
        check("rst_mid_frame_err", 32'(frame_err), 32'h0);
        check("rst_mid_busy",      32'(busy),      32'h0);
        step(); step();
        rst = 1'b0;
        wait_ticks(OS - OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    rxd = stop_bit;
    wait_ticks(OS);
  endtask

  task automatic ack_pulse();
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
  endtask

  task automatic ack_at_stop();
    int g = 0;
    while (!(m_in_frame && m_off == STOP_OFF - 1) && g < 3000) begin
      step();
      g++;
    end
    check("ack_sync_found", 32'(g < 3000), 32'h1);
    if (g < 3000) ack_pulse();
  endtask

  initial begin
    int            f0;
    logic [DB-1:0] d;
    logic          sb;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_rx_data",   32'(rx_data),   32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    rst = 1'b0;
    idle(3);

    // Basic frame, tick every 26 clk.
    send_frame(8'hA5, 1'b1, -1);
    idle(OS);
    check("a5_rx_data",   32'(rx_data),   32'hA5);
    check("a5_model",     32'(m_data),    32'hA5);
    check("a5_rx_valid",  32'(rx_valid),  32'h1);
    check("a5_frame_err", 32'(frame_err), 32'h0);
    check("a5_overrun",   32'(overrun),   32'h0);
    check("a5_busy",      32'(busy),      32'h0);
    ack_pulse();
    check("a5_acked",     32'(rx_valid),  32'h0);

    // False start: line low for a single tick period.
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(1);
    rxd = 1'b1;
    check("glitch_busy_on",   32'(busy),     32'h1);
    wait_ticks(OS / 2 + 1);
    check("glitch_busy_off",  32'(busy),     32'h0);
    check("glitch_rx_valid",  32'(rx_valid), 32'h0);
    idle(OS);

    // Break: 0x00 with the line held low for 20 bit times.
    f0 = ferr_pulses;
    send_frame(8'h00, 1'b0, -1);
    wait_ticks(20 * OS);
    check("break_busy",      32'(busy),                32'h1);
    check("break_rx_valid",  32'(rx_valid),            32'h0);
    check("break_ferr_once", 32'(ferr_pulses - f0),    32'h1);
    idle(2);
    check("break_released",  32'(busy),                32'h0);
    send_frame(8'h3C, 1'b1, -1);
    idle(OS);
    check("after_break_data",  32'(rx_data),  32'h3C);
    check("after_break_valid", 32'(rx_valid), 32'h1);
    ack_pulse();

    // Overrun: two frames, no ack.
    send_frame(8'h12, 1'b1, -1);
    idle(OS);
    send_frame(8'h34, 1'b1, -1);
    idle(OS);
    check("ovr_rx_data",  32'(rx_data),  32'h12);
    check("ovr_rx_valid", 32'(rx_valid), 32'h1);
    check("ovr_overrun",  32'(overrun),  32'h1);
    check("ovr_model",    32'(m_ovr),    32'h1);
    ack_pulse();
    check("ovr_ack_valid",   32'(rx_valid), 32'h0);
    check("ovr_ack_overrun", 32'(overrun),  32'h0);

    // Ack in the same clk as a new load while 0x12 is pending.
    send_frame(8'h12, 1'b1, -1);
    idle(OS);
    tick_div = 1;
    step(); step(); step();
    fork
      send_frame(8'h56, 1'b1, -1);
      ack_at_stop();
    join
    idle(OS);
    check("ackload_rx_valid", 32'(rx_valid), 32'h1);
    check("ackload_rx_data",  32'(rx_data),  32'h56);
    check("ackload_overrun",  32'(overrun),  32'h0);
    ack_pulse();
    tick_div = 26;
    idle(2);

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    send_frame(8'hFF, 1'b1, 4);
    idle(2 * OS);
    check("rst_frame_dropped", 32'(rx_valid), 32'h0);
    check("rst_busy_idle",     32'(busy),     32'h0);
    send_frame(8'h81, 1'b1, -1);
    idle(OS);
    check("post_rst_data",  32'(rx_data),  32'h81);
    check("post_rst_valid", 32'(rx_valid), 32'h1);
    ack_pulse();

    // Random frames, tick rates and acks; occasional bad stop bits.
    ack_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick_div = int'($urandom_range(1, 4));
      d  = DB'($urandom);
      sb = ($urandom_range(0, 9) != 0);
      send_frame(d, sb, -1);
      if (!sb) wait_ticks(int'($urandom_range(0, 3 * OS)));
      idle(int'($urandom_range(1, 2 * OS)));
    end
    ack_rand = 1'b0;
    idle(2 * OS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
